stepdown_state_rx: RTL and testbench

- Receive-end qualifier for the stepdown core-state line. The line arrives inverted, after the core-state inverter stage.
- Synchronises the line into the CELCLK domain, deglitches it, re-inverts it and emits a clean state level.
- Also emits rise/fall pulses and a saturating event count for the stepdown controller.

---
 rtl/stepdown_state_rx.sv | 185 ++++++++++++++++++
 tb/tb_stepdown_state_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepdown_state_rx.sv
// stepdown_state_rx: synchronises, deglitches and re-inverts the inverted stepdown core-state line.
// Optional macro STEPDOWN_STATE_RX_GLITCH_CNT_EN adds an 8-bit saturating glitch_cnt output.
module stepdown_state_rx #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEGLITCH_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             CELCLK,
    input  logic             CELRSTN,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             i,
    input  logic             en,
    input  logic             clr,
    output logic             o,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] evt_cnt,
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
    output logic [7:0]       glitch_cnt,
`endif
    output logic             evt_ovf
);

    localparam int QW = (DEGLITCH_CYCLES > 2) ? $clog2(DEGLITCH_CYCLES) : 1;
    localparam logic [QW-1:0]    Q_ONE   = QW'(1);
    localparam logic [QW-1:0]    Q_LAST  = QW'(DEGLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [QW-1:0]          q, q_next;
    logic                   o_next, rise_next, fall_next, glitch_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    // Supply and substrate pins carry no logic; they are only folded here.
    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB};

    // Idle line is high (recovered low), so the synchroniser resets to ones.
    always_ff @(posedge CELCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!CELRSTN) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i};
        end
    end

    assign s = ~sync[SYNC_STAGES-1];

    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state  <= LOW;
            q      <= '0;
            o      <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            state  <= state_next;
            q      <= q_next;
            o      <= o_next;
            rise   <= rise_next;
            fall   <= fall_next;
            glitch <= glitch_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_next  = state;
        q_next      = q;
        o_next      = o;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = 1'b0;

        if (!en) begin
            // Forced drop of o is silent: no fall pulse.
            state_next = LOW;
            q_next     = '0;
            o_next     = 1'b0;
        end else begin
            unique case (state)
                LOW: begin
                    if (s) begin
                        if (DEGLITCH_CYCLES == 1) begin
                            state_next = HIGH;
                            o_next     = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            state_next = QUAL_HI;
                            q_next     = Q_ONE;
                        end
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_next  = LOW;
                        q_next      = '0;
                        glitch_next = 1'b1;
                    end else if (q == Q_LAST) begin
                        state_next = HIGH;
                        q_next     = '0;
                        o_next     = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        q_next = q + Q_ONE;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        if (DEGLITCH_CYCLES == 1) begin
                            state_next = LOW;
                            o_next     = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            state_next = QUAL_LO;
                            q_next     = Q_ONE;
                        end
                    end
                end
                QUAL_LO: begin
                    if (s) begin
                        state_next  = HIGH;
                        q_next      = '0;
                        glitch_next = 1'b1;
                    end else if (q == Q_LAST) begin
                        state_next = LOW;
                        q_next     = '0;
                        o_next     = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        q_next = q + Q_ONE;
                    end
                end
                default: begin
                    state_next = LOW;
                    q_next     = '0;
                    o_next     = 1'b0;
                end
            endcase
        end
    end

    // Counter advances on the same edge that registers rise; clr takes priority.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
        end else if (clr) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
        end else if (rise_next) begin
            if (evt_cnt == '1) begin
                evt_ovf <= 1'b1;
            end else begin
                evt_cnt <= evt_cnt + CNT_ONE;
            end
        end
    end

`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            glitch_cnt <= '0;
        end else if (clr) begin
            glitch_cnt <= '0;
        end else if (glitch_next && glitch_cnt != 8'hFF) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stepdown_state_rx.sv
// Scoreboard bench for stepdown_state_rx: stimulus queues expected pulses, a monitor pops and compares.
module tb_stepdown_state_rx;

    localparam int CNT_W = 2;

    typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_GLITCH = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       cnt;
        int       ovf;
        int       g;
    } ev_t;

    logic CELCLK = 1'b0;
    logic CELRSTN = 1'b0;
    logic i = 1'b1;
    logic en = 1'b1;
    logic clr = 1'b0;

    logic             o, rise, fall, glitch, evt_ovf;
    logic [CNT_W-1:0] evt_cnt;
    logic             o1, rise1, fall1, glitch1, evt_ovf1;
    logic [7:0]       evt_cnt1;
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
    logic [7:0]       glitch_cnt, glitch_cnt1;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    stepdown_state_rx #(.SYNC_STAGES(2), .DEGLITCH_CYCLES(4), .CNT_W(CNT_W)) dut (
        .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .i(i), .en(en), .clr(clr), .o(o), .rise(rise), .fall(fall), .glitch(glitch),
        .evt_cnt(evt_cnt),
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .evt_ovf(evt_ovf)
    );

    stepdown_state_rx #(.SYNC_STAGES(2), .DEGLITCH_CYCLES(1), .CNT_W(8)) dut_d1 (
        .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .i(i), .en(en), .clr(clr), .o(o1), .rise(rise1), .fall(fall1), .glitch(glitch1),
        .evt_cnt(evt_cnt1),
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt1),
`endif
        .evt_ovf(evt_ovf1)
    );

    always #5 CELCLK = ~CELCLK;

    always @(posedge CELCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CELCLK);
    endtask

    task automatic push(input ev_kind_t k, input int c, input int cnt, input int ovf, input int g);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cnt  = cnt;
        e.ovf  = ovf;
        e.g    = g;
        exp_q.push_back(e);
    endtask

    // Monitor: any pulse on the main instance must match the head of the expected queue.
    always @(negedge CELCLK) begin
        if (rise || fall || glitch) begin
            check("pulse_exclusive", int'(rise) + int'(fall) + int'(glitch), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", rise ? 0 : (fall ? 1 : 2), int'(mon_e.kind));
                check("pulse_cycle", cyc, mon_e.cyc);
                check("evt_cnt_at_pulse", int'(evt_cnt), mon_e.cnt);
                check("evt_ovf_at_pulse", int'(evt_ovf), mon_e.ovf);
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
                check("glitch_cnt_at_pulse", int'(glitch_cnt), mon_e.g);
`endif
            end
        end
    end

    initial begin
        // Reset with idle line, then 20 quiet cycles.
        tick(3);
        check("reset_o", int'(o), 0);
        check("reset_evt_cnt", int'(evt_cnt), 0);
        check("reset_evt_ovf", int'(evt_ovf), 0);
        check("reset_pulses", int'(rise) + int'(fall) + int'(glitch), 0);
        CELRSTN = 1'b1;
        tick(20);
        check("idle_o", int'(o), 0);
        check("idle_evt_cnt", int'(evt_cnt), 0);
        check("idle_d1_o", int'(o1), 0);

        // Clean 1->0 on i: o rises on the 6th edge counting the sampling edge.
        i = 1'b0;
        n0 = cyc;
        push(EV_RISE, n0 + 6, 1, 0, 0);
        tick(2);
        check("d1_o_before", int'(o1), 0);
        tick(1);
        check("d1_o_after", int'(o1), 1);
        check("d1_rise", int'(rise1), 1);
        check("d1_evt_cnt", int'(evt_cnt1), 1);
        tick(2);
        check("o_before_latency", int'(o), 0);
        tick(1);
        check("o_at_latency", int'(o), 1);
        tick(4);

        // Back low, then a 3-cycle low pulse that must abort as a glitch.
        i = 1'b1;
        n0 = cyc;
        push(EV_FALL, n0 + 6, 1, 0, 0);
        tick(8);
        i = 1'b0;
        n0 = cyc;
        push(EV_GLITCH, n0 + 6, 1, 0, 1);
        tick(3);
        i = 1'b1;
        tick(6);
        check("o_after_glitch", int'(o), 0);

        // Rise, then drop en while o=1 (silent drop), re-enable with i held low.
        i = 1'b0;
        n0 = cyc;
        push(EV_RISE, n0 + 6, 2, 0, 1);
        tick(8);
        en = 1'b0;
        n0 = cyc;
        tick(1);
        check("en_drop_o", int'(o), 0);
        check("en_drop_d1_fall", int'(fall1), 0);
        check("en_drop_evt_cnt", int'(evt_cnt), 2);
        tick(1);
        en = 1'b1;
        push(EV_RISE, n0 + 6, 3, 0, 1);
        tick(3);
        check("en_restart_o_before", int'(o), 0);
        tick(1);
        check("en_restart_o", int'(o), 1);
        tick(3);

        // Fourth rise saturates the 2-bit counter and sets overflow.
        i = 1'b1;
        n0 = cyc;
        push(EV_FALL, n0 + 6, 3, 0, 1);
        tick(8);
        i = 1'b0;
        n0 = cyc;
        push(EV_RISE, n0 + 6, 3, 1, 1);
        tick(8);
        i = 1'b1;
        n0 = cyc;
        push(EV_FALL, n0 + 6, 3, 1, 1);
        tick(8);

        // Fifth rise with clr coincident: clr wins.
        i = 1'b0;
        n0 = cyc;
        push(EV_RISE, n0 + 6, 0, 0, 0);
        tick(5);
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        tick(2);
        check("clr_evt_cnt", int'(evt_cnt), 0);
        check("clr_evt_ovf", int'(evt_ovf), 0);

        // Two-cycle high blip while o=1 aborts QUAL_LO.
        i = 1'b1;
        n0 = cyc;
        push(EV_GLITCH, n0 + 5, 0, 0, 1);
        tick(2);
        i = 1'b0;
        tick(6);
        check("o_after_hi_glitch", int'(o), 1);

        // Reset during QUAL_HI at q=2 discards the pending rise.
        i = 1'b1;
        n0 = cyc;
        push(EV_FALL, n0 + 6, 0, 0, 1);
        tick(8);
        i = 1'b0;
        tick(4);
        CELRSTN = 1'b0;
        tick(1);
        check("midqual_reset_o", int'(o), 0);
        check("midqual_reset_d1_o", int'(o1), 0);
        CELRSTN = 1'b1;
        n0 = cyc;
        push(EV_RISE, n0 + 6, 1, 0, 0);
        tick(5);
        check("post_reset_o_before", int'(o), 0);
        tick(1);
        check("post_reset_o_latency", int'(o), 1);
        tick(6);

        check("d1_no_glitch", int'(glitch1), 0);
        check("d1_no_ovf", int'(evt_ovf1), 0);
`ifdef STEPDOWN_STATE_RX_GLITCH_CNT_EN
        check("d1_glitch_cnt", int'(glitch_cnt1), 0);
`endif
        check("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
